// File: rtl/sie_pkg.sv
// Shared SIE phase codes, envelope constants and small helper functions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sie_pkg;

    // Duration inputs and the tick counter are this wide.
    localparam int SIE_DUR_W = 16;

    // Q14 unity; the envelope tops out exactly here.
    localparam int ENV_ONE = 16384;

    // Phase codes double as the external sie_phase encoding (code 1 unused).
    typedef enum logic [2:0] {
        SIE_IDLE  = 3'd0,
        SIE_COH   = 3'd2,
        SIE_IGN   = 3'd3,
        SIE_PLAT  = 3'd4,
        SIE_PROP  = 3'd5,
        SIE_DECAY = 3'd6,
        SIE_REFR  = 3'd7
    } sie_phase_e;

    // A zero duration still occupies one tick.
    function automatic logic [SIE_DUR_W-1:0] eff_dur(input logic [SIE_DUR_W-1:0] dur);
        return (dur == '0) ? SIE_DUR_W'(1) : dur;
    endfunction

    // Normal (non-abort) successor of each active phase.
    function automatic sie_phase_e next_phase(input sie_phase_e ph);
        case (ph)
            SIE_COH:   return SIE_IGN;
            SIE_IGN:   return SIE_PLAT;
            SIE_PLAT:  return SIE_PROP;
            SIE_PROP:  return SIE_DECAY;
            SIE_DECAY: return SIE_REFR;
            default:   return SIE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sie_ramp_divider.sv
// Restoring unsigned divider (N_W-bit dividend / D_W-bit divisor) for the envelope ramps.
// Latency: start sampled on one edge, N_W iteration cycles, o_done pulses for one clk afterwards.
// Backpressure: none; a new start reloads the operands and abandons any division in flight.
module sie_ramp_divider #(
    parameter int N_W = 30,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [N_W-1:0] i_dividend,
    input  logic [D_W-1:0] i_divisor,
    output logic           o_done,
    output logic [D_W-1:0] o_quotient
);

    localparam int CNT_W = $clog2(N_W + 1);

    logic [N_W-1:0]   r_quo;
    logic [D_W-1:0]   r_rem;
    logic [D_W-1:0]   r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [D_W:0]     w_shift;
    logic             w_fits;
    logic [D_W-1:0]   w_diff;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        w_shift = {r_rem, r_quo[N_W-1]};
        w_fits  = (w_shift >= {1'b0, r_div});
        // When the divisor fits, the difference is below the divisor and so fits in D_W bits.
        w_diff  = D_W'(w_shift - {1'b0, r_div});
    end

    // Iteration control: load on start, then N_W shift/subtract cycles, done pulse at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quo  <= i_dividend;
                r_rem  <= '0;
                r_div  <= i_divisor;
                r_cnt  <= CNT_W'(N_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {r_quo[N_W-2:0], w_fits};
                r_rem <= w_fits ? w_diff : w_shift[D_W-1:0];
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo[D_W-1:0];

endmodule

// File: rtl/sie_phase_sequencer.sv
// SIE phase timeline: IDLE -> COH -> IGN -> PLAT -> PROP -> DECAY -> REFR -> IDLE in 4 kHz ticks, Q14 envelope.
// Latency: phase/start/constant envelope on the clk_en edge; ramp envelope 32 clk after that edge.
// Backpressure: none; triggers outside IDLE are dropped, clk_en must be spaced beyond the divider run.
module sie_phase_sequencer
    import sie_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    sie_enable,
    input  logic                    sie_trigger,
    input  logic [SIE_DUR_W-1:0]    sie_phase2_dur,
    input  logic [SIE_DUR_W-1:0]    sie_phase3_dur,
    input  logic [SIE_DUR_W-1:0]    sie_phase4_dur,
    input  logic [SIE_DUR_W-1:0]    sie_phase5_dur,
    input  logic [SIE_DUR_W-1:0]    sie_phase6_dur,
    input  logic [SIE_DUR_W-1:0]    sie_refractory,
    output logic [2:0]              sie_phase,
    output logic                    sie_active,
    output logic                    sie_phase_start,
    output logic signed [WIDTH-1:0] sie_envelope,
    output logic [15:0]             sie_event_count
);

    localparam int               DIV_N_W   = SIE_DUR_W + FRAC;
    localparam logic [WIDTH-1:0] L_ENV_ONE = WIDTH'(ENV_ONE);

    // Latched (already max(dur,1)) durations: COH, IGN, PLAT, PROP, DECAY, REFR.
    logic [SIE_DUR_W-1:0] r_dur [0:5];

    sie_phase_e           r_phase;
    logic [SIE_DUR_W-1:0] r_elapsed;
    logic                 r_start;
    logic                 r_div_start;
    logic [WIDTH-1:0]     r_env;
    logic [15:0]          r_event_count;

    sie_phase_e           w_phase_nxt;
    logic                 w_enter;
    logic [SIE_DUR_W-1:0] w_cur_dur;
    logic                 w_phase_done;
    logic [15:0]          w_count_nxt;
    logic [DIV_N_W-1:0]   w_dividend;
    logic                 w_div_done;
    logic [SIE_DUR_W-1:0] w_quo;

    // Duration of whichever phase is current; IDLE borrows the refractory slot harmlessly.
    always_comb begin
        w_cur_dur = r_dur[5];
        case (r_phase)
            SIE_COH:   w_cur_dur = r_dur[0];
            SIE_IGN:   w_cur_dur = r_dur[1];
            SIE_PLAT:  w_cur_dur = r_dur[2];
            SIE_PROP:  w_cur_dur = r_dur[3];
            SIE_DECAY: w_cur_dur = r_dur[4];
            default:   w_cur_dur = r_dur[5];
        endcase
        // >= rather than == keeps the FSM moving even after a spacing violation.
        w_phase_done = (r_elapsed >= w_cur_dur);
    end

    // Next-state logic; w_enter flags entry into a non-IDLE phase on this tick.
    always_comb begin
        w_phase_nxt = r_phase;
        w_enter     = 1'b0;
        if (clk_en) begin
            case (r_phase)
                SIE_IDLE: begin
                    if (sie_trigger && sie_enable) begin
                        w_phase_nxt = SIE_COH;
                        w_enter     = 1'b1;
                    end
                end
                SIE_COH, SIE_IGN, SIE_PLAT, SIE_PROP, SIE_DECAY: begin
                    if (!sie_enable) begin
                        w_phase_nxt = SIE_REFR;
                        w_enter     = 1'b1;
                    end else if (w_phase_done) begin
                        w_phase_nxt = next_phase(r_phase);
                        w_enter     = 1'b1;
                    end
                end
                SIE_REFR: begin
                    if (w_phase_done) begin
                        w_phase_nxt = SIE_IDLE;
                    end
                end
                default: begin
                    w_phase_nxt = SIE_IDLE;
                end
            endcase
        end
    end

    // Phase state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= SIE_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Decoded phase outputs.
    always_comb begin
        sie_phase  = r_phase;
        sie_active = (r_phase inside {SIE_COH, SIE_IGN, SIE_PLAT, SIE_PROP, SIE_DECAY});
    end

    // Tick counter, duration latches, start pulse and divider kick-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                r_dur[i] <= '0;
            end
            r_elapsed   <= '0;
            r_start     <= 1'b0;
            r_div_start <= 1'b0;
        end else begin
            r_start     <= w_enter;
            r_div_start <= 1'b0;
            if (clk_en) begin
                // Durations are captured only at trigger and held through refractory.
                if (r_phase == SIE_IDLE && w_enter) begin
                    r_dur[0] <= eff_dur(sie_phase2_dur);
                    r_dur[1] <= eff_dur(sie_phase3_dur);
                    r_dur[2] <= eff_dur(sie_phase4_dur);
                    r_dur[3] <= eff_dur(sie_phase5_dur);
                    r_dur[4] <= eff_dur(sie_phase6_dur);
                    r_dur[5] <= eff_dur(sie_refractory);
                end
                if (w_enter) begin
                    r_elapsed <= SIE_DUR_W'(1);
                end else if (w_phase_nxt == SIE_IDLE) begin
                    r_elapsed <= '0;
                end else if (r_elapsed != '1) begin
                    r_elapsed <= r_elapsed + 1'b1;
                end
                // Ramp phases recompute the envelope from the freshly updated counter.
                r_div_start <= (w_phase_nxt == SIE_IGN) || (w_phase_nxt == SIE_DECAY);
            end
        end
    end

    assign w_dividend = DIV_N_W'(r_elapsed) << FRAC;

    sie_ramp_divider #(
        .N_W (DIV_N_W),
        .D_W (SIE_DUR_W)
    ) u_ramp_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (r_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_cur_dur),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // Envelope: constants load on the tick; ramps load when the divider finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_env <= '0;
        end else if (clk_en) begin
            case (w_phase_nxt)
                SIE_PLAT, SIE_PROP: r_env <= L_ENV_ONE;
                SIE_IGN, SIE_DECAY: r_env <= r_env;
                default:            r_env <= '0;
            endcase
        end else if (w_div_done) begin
            // A late result is dropped if the phase has since left the ramp it was computed for.
            if (r_phase == SIE_IGN) begin
                r_env <= WIDTH'(w_quo);
            end else if (r_phase == SIE_DECAY) begin
                r_env <= L_ENV_ONE - WIDTH'(w_quo);
            end
        end
    end

    // Event count advances once per refractory entry and sticks at full scale.
    always_comb begin
        w_count_nxt = r_event_count;
        if (w_enter && (w_phase_nxt == SIE_REFR) && (r_event_count != 16'hFFFF)) begin
            w_count_nxt = r_event_count + 16'd1;
        end
    end

    // Event counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_event_count <= '0;
        end else begin
            r_event_count <= w_count_nxt;
        end
    end

    assign sie_phase_start = r_start;
    assign sie_envelope    = r_env;
    assign sie_event_count = r_event_count;

endmodule

// File: tb/tb_sie_phase_sequencer.sv
// Bench for sie_phase_sequencer: directed scenarios plus random ticks against a schedule-queue model.
// Latency: samples on the falling edge after each clk_en edge and 31/32 clk later for ramps.
// Backpressure: n/a; ticks are spaced 46 clk apart.
module tb_sie_phase_sequencer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clk_en = 1'b0;
    logic               sie_enable = 1'b1;
    logic               sie_trigger = 1'b0;
    logic [15:0]        sie_phase2_dur = 16'd1;
    logic [15:0]        sie_phase3_dur = 16'd1;
    logic [15:0]        sie_phase4_dur = 16'd1;
    logic [15:0]        sie_phase5_dur = 16'd1;
    logic [15:0]        sie_phase6_dur = 16'd1;
    logic [15:0]        sie_refractory = 16'd1;
    logic [2:0]         sie_phase;
    logic               sie_active;
    logic               sie_phase_start;
    logic signed [17:0] sie_envelope;
    logic [15:0]        sie_event_count;

    sie_phase_sequencer #(.WIDTH(18), .FRAC(14)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .sie_enable      (sie_enable),
        .sie_trigger     (sie_trigger),
        .sie_phase2_dur  (sie_phase2_dur),
        .sie_phase3_dur  (sie_phase3_dur),
        .sie_phase4_dur  (sie_phase4_dur),
        .sie_phase5_dur  (sie_phase5_dur),
        .sie_phase6_dur  (sie_phase6_dur),
        .sie_refractory  (sie_refractory),
        .sie_phase       (sie_phase),
        .sie_active      (sie_active),
        .sie_phase_start (sie_phase_start),
        .sie_envelope    (sie_envelope),
        .sie_event_count (sie_event_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Model: on trigger the whole event is laid out as one queue entry per tick.
    typedef struct {
        int ph;
        int k;
        int d;
    } sched_t;

    sched_t q[$];
    int     m_lat[6];
    int     m_ph    = 0;
    int     m_cnt   = 0;
    int     m_env   = 0;
    bit     m_start = 1'b0;
    bit     m_ramp  = 1'b0;

    function automatic int eff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    function automatic void build_from(input int first);
        for (int i = first; i < 6; i++) begin
            for (int k = 1; k <= m_lat[i]; k++) begin
                q.push_back('{ph: (i < 5) ? i + 2 : 7, k: k, d: m_lat[i]});
            end
        end
        q.push_back('{ph: 0, k: 1, d: 1});
    endfunction

    function automatic void model_tick(input bit trig, input bit en);
        sched_t e;
        if (m_ph >= 2 && m_ph <= 6 && !en) begin
            q.delete();
            build_from(5);
        end else if (q.size() == 0 && trig && en) begin
            m_lat[0] = eff(sie_phase2_dur);
            m_lat[1] = eff(sie_phase3_dur);
            m_lat[2] = eff(sie_phase4_dur);
            m_lat[3] = eff(sie_phase5_dur);
            m_lat[4] = eff(sie_phase6_dur);
            m_lat[5] = eff(sie_refractory);
            build_from(0);
        end
        if (q.size() == 0) e = '{ph: 0, k: 1, d: 1};
        else               e = q.pop_front();
        m_start = (e.ph != 0) && (e.k == 1);
        if (e.ph == 7 && e.k == 1 && m_cnt < 65535) m_cnt++;
        m_ph   = e.ph;
        m_ramp = (e.ph == 3) || (e.ph == 6);
        case (e.ph)
            3:       m_env = (e.k * 16384) / e.d;
            6:       m_env = 16384 - (e.k * 16384) / e.d;
            4, 5:    m_env = 16384;
            default: m_env = 0;
        endcase
    endfunction

    task automatic do_tick(input bit trig, input bit en);
        int prev_env;
        prev_env = m_env;
        @(negedge clk);
        clk_en      = 1'b1;
        sie_trigger = trig;
        sie_enable  = en;
        @(negedge clk);
        clk_en      = 1'b0;
        sie_trigger = 1'b0;
        model_tick(trig, en);
        check_eq("phase", sie_phase, m_ph);
        check_eq("active", sie_active, (m_ph >= 2 && m_ph <= 6) ? 1 : 0);
        check_eq("start", sie_phase_start, m_start);
        check_eq("count", sie_event_count, m_cnt);
        if (sie_phase_start) n_starts++;
        check_eq(m_ramp ? "env_hold_tick" : "env_const", sie_envelope, m_ramp ? prev_env : m_env);
        @(negedge clk);
        check_eq("start_one_clk", sie_phase_start, 0);
        repeat (30) @(negedge clk);
        check_eq("env_hold_31", sie_envelope, m_ramp ? prev_env : m_env);
        @(negedge clk);
        check_eq("env_at_32", sie_envelope, m_env);
        repeat (12) @(negedge clk);
    endtask

    task automatic set_durs(input int a, input int b, input int c, input int d, input int e, input int r);
        sie_phase2_dur = 16'(a);
        sie_phase3_dur = 16'(b);
        sie_phase4_dur = 16'(c);
        sie_phase5_dur = 16'(d);
        sie_phase6_dur = 16'(e);
        sie_refractory = 16'(r);
    endtask

    task automatic run_out(input bit en);
        for (int i = 0; i < 300 && q.size() > 0; i++) do_tick(1'b0, en);
        check_eq("run_out_bound", q.size(), 0);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_phase", sie_phase, 0);
        check_eq("rst_active", sie_active, 0);
        check_eq("rst_start", sie_phase_start, 0);
        check_eq("rst_env", sie_envelope, 0);
        check_eq("rst_count", sie_event_count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full nominal event with ramps of length 8.
        set_durs(4, 8, 2, 6, 8, 4);
        n_starts = 0;
        do_tick(1'b1, 1'b1);
        run_out(1'b1);
        check_eq("start_pulses", n_starts, 6);
        check_eq("count_after_first", sie_event_count, 1);

        // Trigger bursts in PLATEAU and REFRACTORY, then a restart right after IDLE entry.
        set_durs(2, 3, 3, 2, 2, 4);
        do_tick(1'b1, 1'b1);
        for (int i = 0; i < 200 && q.size() > 0; i++) do_tick((m_ph == 4) || (m_ph == 7), 1'b1);
        check_eq("burst_bound", q.size(), 0);
        do_tick(1'b1, 1'b1);
        check_eq("restart_phase", sie_phase, 2);
        run_out(1'b1);

        // Zero ignition duration; inputs scrambled mid-event must not matter.
        set_durs(1, 0, 2, 2, 3, 2);
        do_tick(1'b1, 1'b1);
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            set_durs($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                     $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
            do_tick(1'b0, 1'b1);
        end
        check_eq("scramble_bound", q.size(), 0);

        // Abort in PROPAGATION, enable stays low through refractory, then a disabled trigger.
        set_durs(2, 3, 2, 5, 3, 3);
        do_tick(1'b1, 1'b1);
        for (int i = 0; i < 50 && m_ph != 5; i++) do_tick(1'b0, 1'b1);
        check_eq("reach_prop", sie_phase, 5);
        do_tick(1'b0, 1'b1);
        do_tick(1'b0, 1'b0);
        check_eq("abort_phase", sie_phase, 7);
        run_out(1'b0);
        do_tick(1'b1, 1'b0);
        check_eq("disabled_trig", sie_phase, 0);

        // Reset while the ignition divider is running.
        set_durs(1, 8, 1, 1, 1, 1);
        do_tick(1'b1, 1'b1);
        @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        check_eq("pre_rst_phase", sie_phase, 3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_phase", sie_phase, 0);
        check_eq("mid_rst_active", sie_active, 0);
        check_eq("mid_rst_start", sie_phase_start, 0);
        check_eq("mid_rst_env", sie_envelope, 0);
        check_eq("mid_rst_count", sie_event_count, 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_ph  = 0;
        m_cnt = 0;
        m_env = 0;
        repeat (45) @(negedge clk);
        check_eq("post_rst_env", sie_envelope, 0);
        check_eq("post_rst_phase", sie_phase, 0);
        set_durs(1, 4, 1, 1, 4, 2);
        do_tick(1'b1, 1'b1);
        run_out(1'b1);

        // Saturation of the event counter.
        force dut.r_event_count = 16'hFFFF;
        repeat (3) @(negedge clk);
        release dut.r_event_count;
        m_cnt = 65535;
        @(negedge clk);
        check_eq("forced_count", sie_event_count, 65535);
        set_durs(1, 2, 1, 1, 2, 1);
        do_tick(1'b1, 1'b1);
        run_out(1'b1);
        check_eq("sat_count", sie_event_count, 65535);

        // Random ticks: triggers, enable drops and input churn.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_durs($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                         $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
            end
            do_tick($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
